// File: rtl/spi_shift_engine_pkg.sv
// spi_pkg: shared FSM encoding, width limit and mode record for the SPI shift engine.
package spi_pkg;

    localparam int SPI_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_t;

    typedef struct packed {
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Handshake and serial bundle between the SPI master FSM / pad logic and the shift engine.
// Defining SPI_LSB_FIRST_EN adds the LsbFirst request bit.
interface spi_shift_engine_if #(
    parameter int DATA_W = 8
) ();

    logic              Start;
    logic [DATA_W-1:0] TxData;
    logic              Cpha;
    logic              SckLead;
    logic              SckTrail;
    logic              Miso;
    logic              Abort;
`ifdef SPI_LSB_FIRST_EN
    logic              LsbFirst;
`endif
    logic              Mosi;
    logic [DATA_W-1:0] RxData;
    logic              Busy;
    logic              Done;

`ifdef SPI_LSB_FIRST_EN
    modport master (
        output Start, TxData, Cpha, SckLead, SckTrail, Miso, Abort, LsbFirst,
        input  Mosi, RxData, Busy, Done
    );

    modport slave (
        input  Start, TxData, Cpha, SckLead, SckTrail, Miso, Abort, LsbFirst,
        output Mosi, RxData, Busy, Done
    );
`else
    modport master (
        output Start, TxData, Cpha, SckLead, SckTrail, Miso, Abort,
        input  Mosi, RxData, Busy, Done
    );

    modport slave (
        input  Start, TxData, Cpha, SckLead, SckTrail, Miso, Abort,
        output Mosi, RxData, Busy, Done
    );
`endif

endinterface

// File: rtl/spi_shift_engine_bit_counter.sv
// spi_bit_counter: clearable up-counter for received bits with a terminal-count flag.
module spi_bit_counter #(
    parameter int CNT_W = 4,
    parameter int LAST  = 7
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // High while the next increment completes the word
    assign o_tc = (r_cnt == LAST_CNT);

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: DATA_W-bit SPI shifter with CPHA select, Busy/Done handshake and abort.
// Defining SPI_LSB_FIRST_EN adds LsbFirst, selecting LSB-first shifting per transfer.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input logic               Clk,
    input logic               Rst,
    spi_shift_engine_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_t        r_state;
    spi_state_t        w_next;
    spi_mode_t         r_mode;
    spi_mode_t         w_mode_in;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_done;
    logic              r_skip_lch;
    logic              w_idle;
    logic              w_load;
    logic              w_abort;
    logic              w_smp;
    logic              w_lch;
    logic              w_finish;
    logic              w_tc;

    always_comb begin
        w_mode_in.cpha = bus.Cpha;
`ifdef SPI_LSB_FIRST_EN
        w_mode_in.lsb_first = bus.LsbFirst;
`else
        w_mode_in.lsb_first = 1'b0;
`endif
    end

    assign w_idle   = (r_state == IDLE);
    assign w_load   = w_idle && bus.Start;
    assign w_abort  = !w_idle && bus.Abort;
    assign w_smp    = (r_state == SHIFT) && (r_mode.cpha ? bus.SckTrail : bus.SckLead);
    // Lead and trail together is a protocol error: the sample stands, the launch is dropped
    assign w_lch    = (r_state == SHIFT) && !(bus.SckLead && bus.SckTrail)
                   && (r_mode.cpha ? bus.SckLead : bus.SckTrail);
    assign w_finish = (r_state == DONE) && !bus.Abort;

    spi_bit_counter #(
        .CNT_W (CNT_W),
        .LAST  (DATA_W - 1)
    ) u_bit_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_clr (w_load),
        .i_inc (w_smp),
        .o_tc  (w_tc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.Start) w_next = SHIFT;
            SHIFT: begin
                if (bus.Abort) begin
                    w_next = IDLE;
                end else if (w_smp && w_tc) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = (r_state != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_mode     <= '0;
            r_skip_lch <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_rx_data <= r_rx_shift;
            end

            if (w_load) begin
                r_tx_shift <= bus.TxData;
                r_rx_shift <= '0;
                r_mode     <= w_mode_in;
                // With CPHA=1 bit 0 is already on Mosi, so the first launch is swallowed
                r_skip_lch <= bus.Cpha;
            end else if (w_abort) begin
                r_tx_shift <= '0;
            end else begin
                if (w_smp) begin
                    r_rx_shift <= r_mode.lsb_first ? {bus.Miso, r_rx_shift[DATA_W-1:1]}
                                                   : {r_rx_shift[DATA_W-2:0], bus.Miso};
                end
                if (w_lch) begin
                    if (r_skip_lch) begin
                        r_skip_lch <= 1'b0;
                    end else begin
                        r_tx_shift <= r_mode.lsb_first ? {1'b0, r_tx_shift[DATA_W-1:1]}
                                                       : {r_tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.Mosi   = r_mode.lsb_first ? r_tx_shift[0] : r_tx_shift[DATA_W-1];
    assign bus.RxData = r_rx_data;
    assign bus.Done   = r_done;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: an 8-bit and a 16-bit instance share strobes/Miso.
// The expected serial stream and received word come from the transfer's bit order, not the RTL.
module tb_spi_shift_engine;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    logic        start8    = 1'b0;
    logic        start16   = 1'b0;
    logic        cpha      = 1'b0;
    logic        sck_lead  = 1'b0;
    logic        sck_trail = 1'b0;
    logic        miso      = 1'b0;
    logic        abort     = 1'b0;
    logic [31:0] tx_word   = '0;
`ifdef SPI_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
`endif

    int n_checks   = 0;
    int n_errors   = 0;
    int done8      = 0;
    int done16     = 0;
    int exp_done8  = 0;
    int exp_done16 = 0;

    spi_shift_engine_if #(.DATA_W(8))  bus8  ();
    spi_shift_engine_if #(.DATA_W(16)) bus16 ();

    assign bus8.Start     = start8;
    assign bus8.TxData    = tx_word[7:0];
    assign bus8.Cpha      = cpha;
    assign bus8.SckLead   = sck_lead;
    assign bus8.SckTrail  = sck_trail;
    assign bus8.Miso      = miso;
    assign bus8.Abort     = abort;
    assign bus16.Start    = start16;
    assign bus16.TxData   = tx_word[15:0];
    assign bus16.Cpha     = cpha;
    assign bus16.SckLead  = sck_lead;
    assign bus16.SckTrail = sck_trail;
    assign bus16.Miso     = miso;
    assign bus16.Abort    = abort;
`ifdef SPI_LSB_FIRST_EN
    assign bus8.LsbFirst  = lsb_first;
    assign bus16.LsbFirst = lsb_first;
`endif

    spi_shift_engine #(.DATA_W(8)) u_dut8 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus8.slave)
    );

    spi_shift_engine #(.DATA_W(16)) u_dut16 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus16.slave)
    );

    // Count Done cycles as seen just before each rising edge
    always @(posedge Clk) begin
        if (bus8.Done === 1'b1)  done8++;
        if (bus16.Done === 1'b1) done16++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] f_busy(input bit wide);
        return wide ? 32'(bus16.Busy) : 32'(bus8.Busy);
    endfunction

    function automatic logic [31:0] f_done(input bit wide);
        return wide ? 32'(bus16.Done) : 32'(bus8.Done);
    endfunction

    function automatic logic [31:0] f_mosi(input bit wide);
        return wide ? 32'(bus16.Mosi) : 32'(bus8.Mosi);
    endfunction

    function automatic logic [31:0] f_rx(input bit wide);
        return wide ? 32'(bus16.RxData) : 32'(bus8.RxData);
    endfunction

    // Starts a transfer and plays n bit periods. The k-th sample must see data bit k of tx on
    // Mosi, and Miso carries data bit k of pat (MSB first unless lsb).
    task automatic shift_bits(input bit wide, input logic [31:0] tx, input logic [31:0] pat,
                              input bit c, input bit lsb, input int n, input int gap,
                              input bit inject, input bit with_abort);
        int w;
        int idx;
        w = wide ? 16 : 8;
        tx_word = tx;
        cpha    = c;
        abort   = with_abort;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        if (wide) start16 = 1'b1;
        else      start8  = 1'b1;
        check("busy_idle", f_busy(wide), 32'd0);
        @(negedge Clk);
        start8  = 1'b0;
        start16 = 1'b0;
        abort   = 1'b0;
        check("busy_rise", f_busy(wide), 32'd1);
        check("done_low", f_done(wide), 32'd0);
        check("done_count", wide ? done16 : done8, wide ? exp_done16 : exp_done8);
        check("mosi_first", f_mosi(wide), 32'(tx[lsb ? 0 : w-1]));
        for (int k = 0; k < n; k++) begin
            idx = lsb ? k : w - 1 - k;
            repeat ($urandom_range(gap, 0)) @(negedge Clk);
            if (inject && k == n / 2) begin
                tx_word = 32'hFF;
                if (wide) start16 = 1'b1;
                else      start8  = 1'b1;
                @(negedge Clk);
                start8  = 1'b0;
                start16 = 1'b0;
                tx_word = tx;
                check("start_ignored_busy", f_busy(wide), 32'd1);
            end
            sck_lead = 1'b1;
            if (!c) begin
                miso = pat[idx];
                check("mosi_bit", f_mosi(wide), 32'(tx[idx]));
            end
            @(negedge Clk);
            sck_lead = 1'b0;
            if (c || k != w - 1) begin
                repeat ($urandom_range(gap, 0)) @(negedge Clk);
                sck_trail = 1'b1;
                if (c) begin
                    miso = pat[idx];
                    check("mosi_bit", f_mosi(wide), 32'(tx[idx]));
                end
                @(negedge Clk);
                sck_trail = 1'b0;
            end
            check("busy_hold", f_busy(wide), 32'd1);
        end
    endtask

    // Called one cycle after the final sample; ends on the Done cycle.
    task automatic finish_xfer(input bit wide, input logic [31:0] tx, input logic [31:0] pat,
                               input bit c, input bit lsb);
        int          w;
        logic [31:0] mask;
        w    = wide ? 16 : 8;
        mask = wide ? 32'h0000_FFFF : 32'h0000_00FF;
        if (!c) sck_trail = 1'b1;
        check("busy_in_done", f_busy(wide), 32'd1);
        check("done_early", f_done(wide), 32'd0);
        @(negedge Clk);
        sck_trail = 1'b0;
        check("done_pulse", f_done(wide), 32'd1);
        check("busy_fall", f_busy(wide), 32'd0);
        check("rx_data", f_rx(wide), pat & mask);
        check("mosi_hold", f_mosi(wide), 32'(tx[lsb ? w-1 : 0]));
        if (wide) exp_done16++;
        else      exp_done8++;
    endtask

    initial begin
        logic [31:0] r_tx;
        logic [31:0] r_pat;
        bit          r_wide;
        bit          r_c;

        repeat (3) @(negedge Clk);
        check("rst_mosi8", f_mosi(0), 32'd0);
        check("rst_rx8", f_rx(0), 32'd0);
        check("rst_busy8", f_busy(0), 32'd0);
        check("rst_done8", f_done(0), 32'd0);
        check("rst_busy16", f_busy(1), 32'd0);
        check("rst_rx16", f_rx(1), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        // Basic CPHA=0 transfer, then the same word with a Start injected mid-transfer
        shift_bits(0, 32'hA5, 32'h3C, 0, 0, 8, 1, 0, 0);
        finish_xfer(0, 32'hA5, 32'h3C, 0, 0);
        shift_bits(0, 32'hA5, 32'h3C, 0, 0, 8, 1, 1, 0);
        finish_xfer(0, 32'hA5, 32'h3C, 0, 0);
        @(negedge Clk);

        // Abort after three samples
        shift_bits(0, 32'hF0, 32'h55, 0, 0, 3, 1, 0, 0);
        abort = 1'b1;
        check("abort_busy_pre", f_busy(0), 32'd1);
        check("abort_mosi_pre", f_mosi(0), 32'd1);
        @(negedge Clk);
        abort = 1'b0;
        check("abort_idle", f_busy(0), 32'd0);
        check("abort_mosi", f_mosi(0), 32'd0);
        check("abort_no_done", f_done(0), 32'd0);
        repeat (3) @(negedge Clk);
        check("abort_no_done_late", f_done(0), 32'd0);
        check("abort_rx_keep", f_rx(0), 32'h3C);

        // CPHA=1, 16 bits
        shift_bits(1, 32'h8001, 32'hBEEF, 1, 0, 16, 1, 0, 0);
        finish_xfer(1, 32'h8001, 32'hBEEF, 1, 0);
        @(negedge Clk);

        // Reset after five bits, with strobes arriving during reset
        shift_bits(0, 32'hFF, 32'h9A, 0, 0, 5, 0, 0, 0);
        Rst      = 1'b0;
        sck_lead = 1'b1;
        @(negedge Clk);
        sck_lead  = 1'b0;
        sck_trail = 1'b1;
        check("rst_mid_busy", f_busy(0), 32'd0);
        check("rst_mid_mosi", f_mosi(0), 32'd0);
        check("rst_mid_rx", f_rx(0), 32'd0);
        check("rst_mid_done", f_done(0), 32'd0);
        check("rst_mid_rx16", f_rx(1), 32'd0);
        @(negedge Clk);
        sck_trail = 1'b0;
        Rst       = 1'b1;
        check("rst_hold_busy", f_busy(0), 32'd0);
        check("rst_hold_mosi", f_mosi(0), 32'd0);

        // Start together with Abort in IDLE: Start wins
        shift_bits(0, 32'h5A, 32'hC3, 1, 0, 8, 1, 0, 1);
        finish_xfer(0, 32'h5A, 32'hC3, 1, 0);

        // Randomised back-to-back transfers
        for (int i = 0; i < 16; i++) begin
            r_wide = 1'($urandom_range(1, 0));
            r_c    = 1'($urandom_range(1, 0));
            r_tx   = $urandom;
            r_pat  = $urandom;
            shift_bits(r_wide, r_tx, r_pat, r_c, 0, r_wide ? 16 : 8, 2, 0, 0);
            finish_xfer(r_wide, r_tx, r_pat, r_c, 0);
        end

`ifdef SPI_LSB_FIRST_EN
        shift_bits(0, 32'h01, 32'h01, 0, 1, 8, 1, 0, 0);
        finish_xfer(0, 32'h01, 32'h01, 0, 1);
        lsb_first = 1'b0;
`endif

        @(negedge Clk);
        check("done_single", f_done(0) | f_done(1), 32'd0);
        check("done_total8", done8, exp_done8);
        check("done_total16", done16, exp_done16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised SPI shift engine, the successor to the fixed 8-bit shift register. It loads a word of DATA_W bits and shifts it out on Mosi while it samples Miso into a receive word. An external SCK generator supplies leading and trailing edge strobes. A bit counter, CPHA mode selection, Busy/Done handshake and abort are built in. The block sits between the SPI master control FSM and the pad-level SCK/MOSI/MISO logic.

## Interface
- DATA_W, 8: transfer word length in bits, legal range 2..32.
- CNT_W, $clog2(DATA_W+1): bit counter width. Derived; never overridden.
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  reset, synchronous, active-low.
- Start  in  1  single-cycle request. Loads TxData and starts a transfer; accepted only in IDLE.
- TxData  in  DATA_W  word to transmit, captured on an accepted Start.
- Cpha  in  1  clock phase, captured on an accepted Start.
- SckLead  in  1  single-Clk strobe marking a leading SCK edge.
- SckTrail  in  1  single-Clk strobe marking a trailing SCK edge.
- Miso  in  1  serial input, already synchronised.
- Abort  in  1  aborts the transfer in progress.
- Mosi  out  1  serial output.
- RxData  out  DATA_W  last complete received word.
- Busy  out  1  high in SHIFT and DONE.
- Done  out  1  single-cycle pulse when RxData is updated.

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE to SHIFT on Start:
  - TxShift <= TxData, RxShift <= 0, BitCnt <= 0.
  - Cpha is latched into CphaQ.
- Sample strobe (SmpStb) = CphaQ ? SckTrail : SckLead.
- Launch strobe (LchStb) = CphaQ ? SckLead : SckTrail.
- Mosi = TxShift[DATA_W-1] (MSB first), driven combinationally from the register. In IDLE, Mosi holds the last value loaded or shifted.
- On SmpStb in SHIFT:
  - RxShift <= {RxShift[DATA_W-2:0], Miso}.
  - BitCnt <= BitCnt+1.
- On LchStb in SHIFT: TxShift <= {TxShift[DATA_W-2:0], 1'b0}. Two exceptions:
  - CphaQ=1: the first LchStb after Start is suppressed, because bit 0 is already on Mosi.
  - CphaQ=0: no launch occurs after the DATA_W-th sample.
- When BitCnt reaches DATA_W on a SmpStb, SHIFT goes to DONE. DONE goes to IDLE on the next cycle, with RxData <= RxShift and Done=1 in that cycle.
- Abort in SHIFT or DONE: go to IDLE next cycle. RxData is unchanged, no Done pulse is issued, and TxShift is cleared to 0.
- Abort in IDLE has no effect.
- Start while Busy=1 is ignored, with no queueing.
- Start together with Abort in IDLE: Start wins.
- SckLead and SckTrail in the same cycle is a protocol error. Sample is performed and launch is dropped.
- Strobes in IDLE or DONE are ignored.

## Timing
- Reset values: Mosi=0, RxData=0, Busy=0, Done=0, state IDLE, BitCnt=0, TxShift=0, RxShift=0. Reset overrides everything, including mid-transfer.
- Busy rises the cycle after an accepted Start.
- Done, and the RxData update, occur 2 Clk cycles after the Clk in which the DATA_W-th SmpStb is presented.
- Busy falls in the same cycle Done is high, so a Start in the cycle after Done is accepted. The minimum gap between transfers is one Clk.
- The minimum strobe spacing is 1 Clk; strobes may arrive on consecutive cycles.

## Configuration
- SPI_LSB_FIRST_EN defined:
  - Adds input LsbFirst (1 bit), latched on an accepted Start.
  - When the latched value is 1: Mosi = TxShift[0], TxShift shifts right, and received bits enter at RxShift[DATA_W-1] shifting right. RxData is then bit-ordered like TxData.
- SPI_LSB_FIRST_EN undefined: the LsbFirst port does not exist and operation is MSB-first only.

## Structure
- Package spi_pkg holds:
  - enum spi_state_t {IDLE, SHIFT, DONE};
  - constant SPI_MAX_W = 32;
  - the encoding of a shared mode struct (cpha, lsb_first).
- Sub-module spi_bit_counter (CNT_W-bit, with clear, increment and terminal-count output) is instantiated once for BitCnt.
- The shift registers and FSM live in the top module.

## Test plan
- DATA_W=8, Cpha=0, TxData=8'hA5:
  - Miso driven with the pattern 8'h3C, one bit per SckLead.
  - Mosi yields 1,0,1,0,0,1,0,1.
  - RxData=8'h3C with one Done pulse.
  - Busy spans Start+1 to the Done cycle.
- Cpha=1, DATA_W=16, TxData=16'h8001:
  - Mosi is 1 before the first SckLead.
  - No shift on the first SckLead.
  - RxData captured on SckTrail equals the Miso pattern 16'hBEEF.
- Start asserted during SHIFT with TxData=8'hFF: ignored, and the current transfer of 8'hA5 completes unchanged.
- Abort after 3 samples: IDLE next cycle, no Done, RxData keeps its previous value 8'h3C, and a new Start then works normally.
- Rst low after 5 bits: all outputs return to reset values the next cycle, and strobes during reset are ignored.
- With SPI_LSB_FIRST_EN and LsbFirst=1, TxData=8'h01: the first Mosi bit is 1, and a Miso stream of 1,0,0,0,0,0,0,0 yields RxData=8'h01.
